// File: rtl/conv3x3_sequencer.sv
// conv3x3_sequencer: walks every valid 3x3 window of an IMG_W x IMG_W map,
// issuing one input-memory read per kernel tap and producing PE strobes
// aligned to read data, plus one output-buffer write per window.
module conv3x3_sequencer #(
    parameter int IMG_W   = 8,
    parameter int ADDR_W  = 6,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        tap_idx,
    output logic              pe_en,
    output logic              pe_clr,
    output logic              pe_last,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] base_reg;   // address of the window's top-left pixel
    logic [ADDR_W-1:0] addr_reg;   // address of the tap about to issue
    logic [ADDR_W-1:0] col_reg;
    logic [ADDR_W-1:0] row_reg;
    logic [ADDR_W-1:0] win_reg;    // output index of the current window
    logic [3:0]        tap_reg;
    logic [1:0]        kc_reg;

    logic issue;
    logic last_tap;
    logic last_col;
    logic last_row;
    logic pipe_any;

    // Read-latency pipeline: one entry per cycle of memory latency
    logic              pipe_valid [MEM_LAT];
    logic [3:0]        pipe_tap   [MEM_LAT];
    logic              pipe_clr   [MEM_LAT];
    logic              pipe_last  [MEM_LAT];
    logic [ADDR_W-1:0] pipe_oaddr [MEM_LAT];

    logic              out_we_reg;
    logic [ADDR_W-1:0] out_addr_reg;

    // hold gates the issue directly so a held cycle never produces a read
    assign issue    = (state_reg == RUN) && !hold;
    assign last_tap = (tap_reg == 4'd8);
    assign last_col = (col_reg == ADDR_W'(IMG_W - 3));
    assign last_row = (row_reg == ADDR_W'(IMG_W - 3));

    // Any tap still travelling toward the PE array
    always_comb begin
        pipe_any = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            pipe_any = pipe_any | pipe_valid[i];
        end
    end

    // Pass FSM plus incremental tap/window address counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            base_reg  <= '0;
            addr_reg  <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
            win_reg   <= '0;
            tap_reg   <= '0;
            kc_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                        base_reg  <= '0;
                        addr_reg  <= '0;
                        col_reg   <= '0;
                        row_reg   <= '0;
                        win_reg   <= '0;
                        tap_reg   <= '0;
                        kc_reg    <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (kc_reg != 2'd2) begin
                            // next pixel in the same kernel row
                            addr_reg <= addr_reg + ADDR_W'(1);
                            kc_reg   <= kc_reg + 2'd1;
                            tap_reg  <= tap_reg + 4'd1;
                        end else if (!last_tap) begin
                            // wrap to the start of the next kernel row
                            addr_reg <= addr_reg + ADDR_W'(IMG_W - 2);
                            kc_reg   <= 2'd0;
                            tap_reg  <= tap_reg + 4'd1;
                        end else begin
                            // window finished: step to the next window
                            kc_reg  <= 2'd0;
                            tap_reg <= 4'd0;
                            win_reg <= win_reg + ADDR_W'(1);
                            if (last_col) begin
                                col_reg  <= '0;
                                row_reg  <= row_reg + ADDR_W'(1);
                                base_reg <= base_reg + ADDR_W'(3);
                                addr_reg <= base_reg + ADDR_W'(3);
                                if (last_row) begin
                                    state_reg <= DRAIN;
                                end
                            end else begin
                                col_reg  <= col_reg + ADDR_W'(1);
                                base_reg <= base_reg + ADDR_W'(1);
                                addr_reg <= base_reg + ADDR_W'(1);
                            end
                        end
                    end
                end
                DRAIN: begin
                    // by the time the pipe is empty the final out_we is showing
                    if (!pipe_any) begin
                        state_reg <= DONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Shift tap metadata alongside the memory latency so it meets its data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_tap[i]   <= '0;
                pipe_clr[i]   <= 1'b0;
                pipe_last[i]  <= 1'b0;
                pipe_oaddr[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= issue;
            pipe_tap[0]   <= issue ? tap_reg : 4'd0;
            pipe_clr[0]   <= issue && (tap_reg == 4'd0);
            pipe_last[0]  <= issue && last_tap;
            pipe_oaddr[0] <= win_reg;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_tap[i]   <= pipe_tap[i-1];
                pipe_clr[i]   <= pipe_clr[i-1];
                pipe_last[i]  <= pipe_last[i-1];
                pipe_oaddr[i] <= pipe_oaddr[i-1];
            end
        end
    end

    // Result write one cycle after the PE sees its last tap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_we_reg   <= 1'b0;
            out_addr_reg <= '0;
        end else begin
            out_we_reg <= pipe_valid[MEM_LAT-1] && pipe_last[MEM_LAT-1];
            if (pipe_valid[MEM_LAT-1] && pipe_last[MEM_LAT-1]) begin
                out_addr_reg <= pipe_oaddr[MEM_LAT-1];
            end
        end
    end

    assign mem_rd_en = issue;
    assign mem_addr  = addr_reg;
    assign pe_en     = pipe_valid[MEM_LAT-1];
    assign tap_idx   = pipe_tap[MEM_LAT-1];
    assign pe_clr    = pipe_clr[MEM_LAT-1];
    assign pe_last   = pipe_last[MEM_LAT-1];
    assign out_we    = out_we_reg;
    assign out_addr  = out_addr_reg;
    assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
    assign done      = (state_reg == DONE);
    assign state     = state_reg;

endmodule

// File: tb/tb_conv3x3_sequencer.sv
// Bench for conv3x3_sequencer: three instances (4x4 lat 1, 4x4 lat 3,
// 8x8 lat 1); a reference model fills event queues that are popped as the
// selected instance produces reads, PE strobes, writes and done.
module tb_conv3x3_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic hold = 1'b0;
    logic [1:0] sel = 2'd0;

    logic [2:0] start_v, hold_v;
    logic [2:0] rd_en_v, pe_en_v, clr_v, last_v, we_v, busy_v, done_v;
    logic [5:0] addr_v  [3];
    logic [5:0] oaddr_v [3];
    logic [3:0] tap_v   [3];
    logic [1:0] state_v [3];

    logic       obs_rd, obs_pe, obs_clr, obs_last, obs_we, obs_busy, obs_done;
    logic [5:0] obs_addr, obs_oaddr;
    logic [3:0] obs_tap;
    logic [1:0] obs_state;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t rd_q[$];
    ev_t pe_q[$];
    ev_t we_q[$];

    int total = 0;
    int bad = 0;
    int last_rd_addr, last_we_addr, done_cnt;

    always #5 clk = ~clk;

    assign start_v[0] = start && (sel == 2'd0);
    assign start_v[1] = start && (sel == 2'd1);
    assign start_v[2] = start && (sel == 2'd2);
    assign hold_v[0]  = hold && (sel == 2'd0);
    assign hold_v[1]  = hold && (sel == 2'd1);
    assign hold_v[2]  = hold && (sel == 2'd2);

    assign obs_rd    = rd_en_v[sel];
    assign obs_pe    = pe_en_v[sel];
    assign obs_clr   = clr_v[sel];
    assign obs_last  = last_v[sel];
    assign obs_we    = we_v[sel];
    assign obs_busy  = busy_v[sel];
    assign obs_done  = done_v[sel];
    assign obs_addr  = addr_v[sel];
    assign obs_oaddr = oaddr_v[sel];
    assign obs_tap   = tap_v[sel];
    assign obs_state = state_v[sel];

    conv3x3_sequencer #(.IMG_W(4), .ADDR_W(6), .MEM_LAT(1)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .hold(hold_v[0]),
        .mem_rd_en(rd_en_v[0]), .mem_addr(addr_v[0]), .tap_idx(tap_v[0]),
        .pe_en(pe_en_v[0]), .pe_clr(clr_v[0]), .pe_last(last_v[0]),
        .out_we(we_v[0]), .out_addr(oaddr_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .state(state_v[0])
    );

    conv3x3_sequencer #(.IMG_W(4), .ADDR_W(6), .MEM_LAT(3)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .hold(hold_v[1]),
        .mem_rd_en(rd_en_v[1]), .mem_addr(addr_v[1]), .tap_idx(tap_v[1]),
        .pe_en(pe_en_v[1]), .pe_clr(clr_v[1]), .pe_last(last_v[1]),
        .out_we(we_v[1]), .out_addr(oaddr_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .state(state_v[1])
    );

    conv3x3_sequencer #(.IMG_W(8), .ADDR_W(6), .MEM_LAT(1)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .hold(hold_v[2]),
        .mem_rd_en(rd_en_v[2]), .mem_addr(addr_v[2]), .tap_idx(tap_v[2]),
        .pe_en(pe_en_v[2]), .pe_clr(clr_v[2]), .pe_last(last_v[2]),
        .out_we(we_v[2]), .out_addr(oaddr_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .state(state_v[2])
    );

    // Builds the expected event queues for one pass, starts it and scores
    // every cycle. Cycle 1 is the first cycle after the edge sampling start.
    // hold is high in cycles hs..he; extra start pulses at rs1/rs2;
    // rst_at > 0 aborts the pass with an asynchronous reset in that cycle.
    task automatic run_pass(input int w, input int lat, input int hs, input int he,
                            input int rs1, input int rs2, input int rst_at);
        int  t, t8, exp_done;
        ev_t e;
        rd_q.delete();
        pe_q.delete();
        we_q.delete();
        t  = 1;
        t8 = 0;
        for (int r = 0; r <= w - 3; r++) begin
            for (int c = 0; c <= w - 3; c++) begin
                for (int k = 0; k < 9; k++) begin
                    while (t >= hs && t <= he) t++;
                    e.cyc = t;
                    e.val = (r + k / 3) * w + c + k % 3;
                    rd_q.push_back(e);
                    e.cyc = t + lat;
                    e.val = k;
                    pe_q.push_back(e);
                    if (k == 8) t8 = t;
                    t++;
                end
                e.cyc = t8 + lat + 1;
                e.val = r * (w - 2) + c;
                we_q.push_back(e);
            end
        end
        exp_done = t8 + lat + 2;
        done_cnt = 0;

        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        for (int rel = 1; rel <= exp_done + 2; rel++) begin
            hold  = (rel >= hs && rel <= he);
            start = (rel == rs1 || rel == rs2);
            if (rel == rst_at) begin
                rst = 1'b1;
                #1;
                total++;
                if (obs_rd !== 1'b0 || obs_addr !== 6'd0 || obs_tap !== 4'd0 ||
                    obs_pe !== 1'b0 || obs_clr !== 1'b0 || obs_last !== 1'b0 ||
                    obs_we !== 1'b0 || obs_oaddr !== 6'd0 || obs_busy !== 1'b0 ||
                    obs_done !== 1'b0 || obs_state !== 2'd0) begin
                    bad++;
                    $display("FAIL async_reset: rd=%0b addr=%0d tap=%0d pe=%0b clr=%0b last=%0b we=%0b oaddr=%0d busy=%0b done=%0b state=%0d, required all 0",
                             obs_rd, obs_addr, obs_tap, obs_pe, obs_clr, obs_last,
                             obs_we, obs_oaddr, obs_busy, obs_done, obs_state);
                end
                break;
            end
            @(negedge clk);
            if (obs_rd) begin
                total++;
                if (rd_q.size() == 0) begin
                    bad++;
                    $display("FAIL read_extra: cycle %0d addr %0d, required no read", rel, obs_addr);
                end else begin
                    e = rd_q.pop_front();
                    if (e.cyc !== rel || e.val !== int'(obs_addr)) begin
                        bad++;
                        $display("FAIL read: cycle %0d addr %0d, required cycle %0d addr %0d",
                                 rel, obs_addr, e.cyc, e.val);
                    end
                    last_rd_addr = obs_addr;
                end
            end
            if (obs_pe) begin
                total++;
                if (pe_q.size() == 0) begin
                    bad++;
                    $display("FAIL pe_extra: cycle %0d tap %0d, required no pe_en", rel, obs_tap);
                end else begin
                    e = pe_q.pop_front();
                    if (e.cyc !== rel || e.val !== int'(obs_tap) ||
                        obs_clr !== (e.val == 0) || obs_last !== (e.val == 8)) begin
                        bad++;
                        $display("FAIL pe: cycle %0d tap %0d clr %0b last %0b, required cycle %0d tap %0d",
                                 rel, obs_tap, obs_clr, obs_last, e.cyc, e.val);
                    end
                end
            end
            total++;
            if ((obs_clr || obs_last) && !obs_pe) begin
                bad++;
                $display("FAIL strobe_without_pe: cycle %0d clr %0b last %0b, required pe_en high", rel, obs_clr, obs_last);
            end
            if (obs_we) begin
                total++;
                if (we_q.size() == 0) begin
                    bad++;
                    $display("FAIL we_extra: cycle %0d out_addr %0d, required no write", rel, obs_oaddr);
                end else begin
                    e = we_q.pop_front();
                    if (e.cyc !== rel || e.val !== int'(obs_oaddr)) begin
                        bad++;
                        $display("FAIL out_we: cycle %0d out_addr %0d, required cycle %0d out_addr %0d",
                                 rel, obs_oaddr, e.cyc, e.val);
                    end
                    last_we_addr = obs_oaddr;
                end
            end
            if (obs_done) begin
                done_cnt++;
                total++;
                if (rel !== exp_done || obs_busy !== 1'b0 || obs_state !== 2'd3) begin
                    bad++;
                    $display("FAIL done: cycle %0d busy %0b state %0d, required cycle %0d busy 0 state 3",
                             rel, obs_busy, obs_state, exp_done);
                end
            end
            total++;
            if (obs_busy !== (rel < exp_done)) begin
                bad++;
                $display("FAIL busy: cycle %0d busy %0b, required %0b", rel, obs_busy, rel < exp_done);
            end
            @(posedge clk);
            #1;
        end
        hold  = 1'b0;
        start = 1'b0;

        if (rst_at > 0) begin
            @(negedge clk);
            rst = 1'b0;
            rd_q.delete();
            pe_q.delete();
            we_q.delete();
        end else begin
            total++;
            if (rd_q.size() != 0 || pe_q.size() != 0 || we_q.size() != 0 ||
                done_cnt !== 1 || obs_state !== 2'd0) begin
                bad++;
                $display("FAIL pass_end: left rd=%0d pe=%0d we=%0d done_cnt=%0d state=%0d, required 0 0 0 1 0",
                         rd_q.size(), pe_q.size(), we_q.size(), done_cnt, obs_state);
            end
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #1;
            total++;
            if (obs_rd !== 1'b0 || obs_addr !== 6'd0 || obs_pe !== 1'b0 ||
                obs_we !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0 ||
                obs_state !== 2'd0 || obs_tap !== 4'd0 || obs_oaddr !== 6'd0) begin
                bad++;
                $display("FAIL reset_state: dut %0d rd=%0b addr=%0d pe=%0b we=%0b busy=%0b done=%0b state=%0d, required all 0",
                         i, obs_rd, obs_addr, obs_pe, obs_we, obs_busy, obs_done, obs_state);
            end
        end
        sel = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        $display("test_reset: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_basic;
        sel = 2'd0;
        run_pass(4, 1, 0, -1, -1, -1, -1);
        $display("test_basic: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_hold;
        sel = 2'd0;
        run_pass(4, 1, 5, 7, -1, -1, -1);
        $display("test_hold: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_latency3;
        sel = 2'd1;
        run_pass(4, 3, 0, -1, -1, -1, -1);
        $display("test_latency3: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_start_ignored;
        sel = 2'd0;
        run_pass(4, 1, 0, -1, 10, 38, -1);
        $display("test_start_ignored: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_async_reset;
        sel = 2'd0;
        run_pass(4, 1, 0, -1, -1, -1, 20);
        run_pass(4, 1, 0, -1, -1, -1, -1);
        $display("test_async_reset: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_back_to_back;
        sel = 2'd1;
        run_pass(4, 3, 2, 3, -1, -1, -1);
        run_pass(4, 3, 0, -1, -1, -1, -1);
        $display("test_back_to_back: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_img8;
        sel = 2'd2;
        last_rd_addr = -1;
        last_we_addr = -1;
        run_pass(8, 1, 0, -1, -1, -1, -1);
        total++;
        if (last_rd_addr !== 63 || last_we_addr !== 35 || done_cnt !== 1) begin
            bad++;
            $display("FAIL img8_last: rd_addr %0d out_addr %0d done_cnt %0d, required 63 35 1",
                     last_rd_addr, last_we_addr, done_cnt);
        end
        $display("test_img8: total=%0d bad=%0d", total, bad);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_hold();
        test_latency3();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        test_img8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv3x3_sequencer.md
# conv3x3_sequencer

Address and control sequencer for the 3x3 convolution stage. On a `start` pulse from the top-level `controller`, it walks every valid 3x3 window of a square IMG_W x IMG_W feature map held in the input memory. It issues one memory read per kernel tap and drives the PE array's clear, accumulate and last strobes aligned to read data. It also generates the output-buffer write strobe and address for each result.

## Interface
- IMG_W, 8: feature-map width and height in pixels; must be ≥ 3.
- ADDR_W, 6: memory address width; IMG_W*IMG_W ≤ 2^ADDR_W.
- MEM_LAT, 1: input-memory read latency in cycles, ≥ 1.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a pass. Ignored unless in IDLE.
- hold  in  1  stall tap issue while high; in-flight pipeline still drains.
- mem_rd_en  out  1  input-memory read strobe.
- mem_addr  out  ADDR_W  input-memory read address.
- tap_idx  out  4  kernel weight index 0..8, aligned with pe_en.
- pe_en  out  1  memory data valid; PE accumulates this cycle.
- pe_clr  out  1  with pe_en on tap 0: PE loads product instead of accumulating.
- pe_last  out  1  with pe_en on tap 8.
- out_we  out  1  output-buffer write strobe, one per window.
- out_addr  out  ADDR_W  output index r*(IMG_W-2)+c.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at end of pass.
- state  out  2  IDLE=0, RUN=1, DRAIN=2, DONE=3.

## Operation
- Window order: r = 0..IMG_W-3 (outer), c = 0..IMG_W-3 (inner). Inside each window, taps k = 0..8 with kr = k/3 and kc = k%3.
- Tap address: (r+kr)*IMG_W + (c+kc).
  - Computed incrementally from a window base register: +1 within a kernel row, +IMG_W-2 at a kernel-row change.
  - Next window base: +1 for the next column; +3 when moving to the next row.
  - No multipliers.
- FSM:
  - IDLE → RUN on start.
  - RUN issues one tap per cycle while hold=0. While hold=1 it issues nothing: mem_rd_en=0 and counters are frozen.
  - RUN → DRAIN after the tap-8 issue of the last window.
  - DRAIN waits until the valid pipeline is empty, then → DONE.
  - DONE lasts one cycle with done=1, then → IDLE.
- Pipeline: a MEM_LAT-deep shift register carries {valid, tap_idx, clr, last, out_addr} from issue to pe_en. A further one-stage register produces out_we and out_addr in the cycle after pe_last.
- hold bubbles propagate through the pipeline as pe_en=0; they never split the alignment between a tap and its data.
- hold is ignored in DRAIN, DONE and IDLE.
- start in RUN, DRAIN or DONE is ignored and does not queue.
- start and hold high in the same cycle: start is accepted; issue begins in the first cycle after hold falls.

## Timing
- Reset (async, any state): state=IDLE. All outputs are 0: mem_rd_en, mem_addr, tap_idx, pe_en, pe_clr, pe_last, out_we, out_addr, busy, done. The pipeline is flushed and counters are cleared. A pass interrupted by reset is abandoned and is not resumed.
- First mem_rd_en is high in the cycle after the edge that samples start.
- Tap issued in cycle t:
  - pe_en, tap_idx, pe_clr, pe_last appear in cycle t+MEM_LAT.
  - The window's out_we appears in cycle t_last+MEM_LAT+1, where t_last is the cycle its tap 8 was issued.
- done occurs in the cycle after the final out_we. With no hold, a pass takes 9*(IMG_W-2)^2 + MEM_LAT + 2 cycles from the first read to done inclusive.
- busy falls in the same cycle that done rises.
- pe_clr and pe_last are never high without pe_en. out_we is never high in the same cycle as pe_clr for the same window.

## Test plan
- IMG_W=4, MEM_LAT=1, start with no hold. Counting the first read cycle as 1:
  - mem_rd_en is high in cycles 1..36.
  - Window 0 addresses: 0,1,2,4,5,6,8,9,10. Window 3 addresses: 5,6,7,9,10,11,13,14,15.
  - out_we at cycles 11, 20, 29, 38 with out_addr 0, 1, 2, 3.
  - done at cycle 39.
- Same setup, hold high in cycles 5..7:
  - Exactly 3 mem_rd_en bubbles.
  - pe_en gaps appear at cycles 6..8.
  - All out_we events and done shift by +3. Address sequence is unchanged.
- MEM_LAT=3, IMG_W=4: pe_en trails mem_rd_en by 3. First out_we at cycle 13; done at cycle 41.
- start pulsed again at cycles 10 and 38 (during RUN and DRAIN): no effect. Exactly 4 out_we and 1 done.
- rst asserted asynchronously mid-RUN at cycle 20:
  - All outputs go to 0 immediately and state=0.
  - A subsequent start produces a full pass identical to the first test.
- IMG_W=8, ADDR_W=6: 36 windows. Last window's tap 8 address is 63 and its out_addr is 35; done is asserted once.
